aclock_set_ctrl: RTL and testbench

User-entry front end for the alarm-clock core. It drives the clock's load interface: H_in1/H_in0/M_in1/M_in0 plus LD_time/LD_alarm. It converts four debounced push-buttons into a digit-by-digit edit session, seeded from the current displayed time or from a shadow copy of the alarm. On confirm it issues a single-cycle load strobe. It runs in the same clk_1s domain in which the core samples its load inputs.

---
 rtl/aclock_pkg.sv | 33 +++
 rtl/aclock_btn_edge.sv | 25 ++
 rtl/aclock_set_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aclock_set_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclock_pkg.sv
// Shared types and digit limits for the alarm-clock user-entry front end.
// Button bit positions match the order used by the edge detector vector.
package aclock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_EDIT_TIME    = 3'd1,
    ST_EDIT_ALARM   = 3'd2,
    ST_COMMIT_TIME  = 3'd3,
    ST_COMMIT_ALARM = 3'd4
  } state_e;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_H2 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  localparam logic [1:0] CUR_H1 = 2'd0;
  localparam logic [1:0] CUR_H0 = 2'd1;
  localparam logic [1:0] CUR_M1 = 2'd2;
  localparam logic [1:0] CUR_M0 = 2'd3;

  localparam int BTN_MODE = 0;
  localparam int BTN_LOAD = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_INC  = 3;

  function automatic logic [3:0] wrap_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/aclock_btn_edge.sv
// Rising-edge detector for the four debounced push-buttons.
// Edges are masked for the first clock after reset so a button held through reset never fires.
module aclock_btn_edge (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [3:0] level_i,
  output logic [3:0] edge_o
);

  logic [3:0] prev_q;
  logic       armed_q;

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      prev_q  <= 4'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign edge_o = armed_q ? (level_i & ~prev_q) : 4'b0;

endmodule

// File: rtl/aclock_set_ctrl.sv
// Digit-by-digit time/alarm edit session driving the clock core's load interface.
// Edit registers feed H_in*/M_in* directly; strobes and status flags are registered from next state.
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_load,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       edit_alarm,
  output logic [1:0] cursor
);

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_S - 1);

  state_e     state_q, state_d;
  logic [1:0] h1_q, h1_d, sh_h1_q, sh_h1_d;
  logic [3:0] h0_q, h0_d, sh_h0_q, sh_h0_d;
  logic [3:0] m1_q, m1_d, sh_m1_q, sh_m1_d;
  logic [3:0] m0_q, m0_d, sh_m0_q, sh_m0_d;
  logic [1:0] cursor_q, cursor_d;
  logic [5:0] timer_q, timer_d;
  logic       ld_time_q, ld_time_d;
  logic       ld_alarm_q, ld_alarm_d;
  logic       editing_q, editing_d;
  logic       edit_alarm_q, edit_alarm_d;
  logic [3:0] btn_edge;

  aclock_btn_edge u_btn_edge (
    .clk_1s  (clk_1s),
    .reset   (reset),
    .level_i ({btn_inc, btn_sel, btn_load, btn_mode}),
    .edge_o  (btn_edge)
  );

  always_comb begin
    state_d  = state_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    sh_h1_d  = sh_h1_q;
    sh_h0_d  = sh_h0_q;
    sh_m1_d  = sh_m1_q;
    sh_m0_d  = sh_m0_q;
    cursor_d = cursor_q;
    timer_d  = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_edge[BTN_MODE]) begin
          state_d  = ST_EDIT_TIME;
          h1_d     = cur_h1;
          h0_d     = cur_h0;
          m1_d     = cur_m1;
          m0_d     = cur_m0;
          cursor_d = CUR_H1;
          timer_d  = 6'd0;
        end
      end

      ST_EDIT_TIME, ST_EDIT_ALARM: begin
        if (|btn_edge) begin
          timer_d = 6'd0;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 6'd1;
        end

        // Only the highest-priority edge acts: mode > load > sel > inc.
        if (btn_edge[BTN_MODE]) begin
          if (state_q == ST_EDIT_TIME) begin
            state_d  = ST_EDIT_ALARM;
            h1_d     = sh_h1_q;
            h0_d     = sh_h0_q;
            m1_d     = sh_m1_q;
            m0_d     = sh_m0_q;
            cursor_d = CUR_H1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (btn_edge[BTN_LOAD]) begin
          if (state_q == ST_EDIT_TIME) begin
            state_d = ST_COMMIT_TIME;
          end else begin
            state_d = ST_COMMIT_ALARM;
            sh_h1_d = h1_q;
            sh_h0_d = h0_q;
            sh_m1_d = m1_q;
            sh_m0_d = m0_q;
          end
        end else if (btn_edge[BTN_SEL]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (btn_edge[BTN_INC]) begin
          case (cursor_q)
            CUR_H1: begin
              h1_d = (h1_q >= H1_MAX) ? 2'd0 : h1_q + 2'd1;
              if ((h1_d == H1_MAX) && (h0_q > H0_MAX_H2)) h0_d = H0_MAX_H2;
            end
            CUR_H0:  h0_d = wrap_inc(h0_q, (h1_q == H1_MAX) ? H0_MAX_H2 : H0_MAX);
            CUR_M1:  m1_d = wrap_inc(m1_q, M1_MAX);
            default: m0_d = wrap_inc(m0_q, M0_MAX);
          endcase
        end
      end

      ST_COMMIT_TIME, ST_COMMIT_ALARM: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    ld_time_d    = (state_d == ST_COMMIT_TIME);
    ld_alarm_d   = (state_d == ST_COMMIT_ALARM);
    editing_d    = (state_d == ST_EDIT_TIME) || (state_d == ST_EDIT_ALARM);
    edit_alarm_d = (state_d == ST_EDIT_ALARM);
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      h1_q         <= 2'd0;
      h0_q         <= 4'd0;
      m1_q         <= 4'd0;
      m0_q         <= 4'd0;
      sh_h1_q      <= 2'd0;
      sh_h0_q      <= 4'd0;
      sh_m1_q      <= 4'd0;
      sh_m0_q      <= 4'd0;
      cursor_q     <= CUR_H1;
      timer_q      <= 6'd0;
      ld_time_q    <= 1'b0;
      ld_alarm_q   <= 1'b0;
      editing_q    <= 1'b0;
      edit_alarm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h1_q         <= h1_d;
      h0_q         <= h0_d;
      m1_q         <= m1_d;
      m0_q         <= m0_d;
      sh_h1_q      <= sh_h1_d;
      sh_h0_q      <= sh_h0_d;
      sh_m1_q      <= sh_m1_d;
      sh_m0_q      <= sh_m0_d;
      cursor_q     <= cursor_d;
      timer_q      <= timer_d;
      ld_time_q    <= ld_time_d;
      ld_alarm_q   <= ld_alarm_d;
      editing_q    <= editing_d;
      edit_alarm_q <= edit_alarm_d;
    end
  end

  assign H_in1      = h1_q;
  assign H_in0      = h0_q;
  assign M_in1      = m1_q;
  assign M_in0      = m0_q;
  assign LD_time    = ld_time_q;
  assign LD_alarm   = ld_alarm_q;
  assign editing    = editing_q;
  assign edit_alarm = edit_alarm_q;
  assign cursor     = cursor_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Directed scenarios followed by random button traffic checked against a session-level model.
// Inputs change on the falling edge; outputs are sampled on the falling edge before driving.
module tb_aclock_set_ctrl;

  localparam int TO = 30;
  localparam int MI = 0, MET = 1, MEA = 2, MCT = 3, MCA = 4;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic       btn_mode, btn_sel, btn_inc, btn_load;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, edit_alarm;
  logic [1:0] cursor;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: session mode, edited time as hours/minutes, alarm shadow
  int       m_mode, m_hh, m_mm, m_sh_hh, m_sh_mm, m_cur, m_idle;
  bit [3:0] m_prev;

  always #5 clk_1s = ~clk_1s;

  aclock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk_1s     (clk_1s),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_sel    (btn_sel),
    .btn_inc    (btn_inc),
    .btn_load   (btn_load),
    .cur_h1     (cur_h1),
    .cur_h0     (cur_h0),
    .cur_m1     (cur_m1),
    .cur_m0     (cur_m0),
    .H_in1      (H_in1),
    .H_in0      (H_in0),
    .M_in1      (M_in1),
    .M_in0      (M_in0),
    .LD_time    (LD_time),
    .LD_alarm   (LD_alarm),
    .editing    (editing),
    .edit_alarm (edit_alarm),
    .cursor     (cursor)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mask bits: 0 mode, 1 load, 2 sel, 3 inc
  task automatic drive(input bit [3:0] mask);
    btn_mode = mask[0];
    btn_load = mask[1];
    btn_sel  = mask[2];
    btn_inc  = mask[3];
  endtask

  task automatic press(input bit [3:0] mask);
    drive(mask);
    @(negedge clk_1s);
    drive(4'b0);
    @(negedge clk_1s);
  endtask

  task automatic set_cur(input int hh, input int mm);
    cur_h1 = 2'(hh / 10);
    cur_h0 = 4'(hh % 10);
    cur_m1 = 4'(mm / 10);
    cur_m0 = 4'(mm % 10);
  endtask

  function automatic logic [15:0] obs_dig();
    return {2'b0, H_in1, H_in0, M_in1, M_in0};
  endfunction

  function automatic logic [15:0] mk_dig(input int hh, input int mm);
    logic [1:0] a;
    logic [3:0] b, c, d;
    a = 2'(hh / 10);
    b = 4'(hh % 10);
    c = 4'(mm / 10);
    d = 4'(mm % 10);
    return {2'b0, a, b, c, d};
  endfunction

  function automatic logic [15:0] obs_flags();
    return {10'b0, LD_time, LD_alarm, editing, edit_alarm, cursor};
  endfunction

  function automatic logic [15:0] exp_flags();
    logic [1:0] c;
    c = 2'(m_cur);
    return {10'b0, m_mode == MCT, m_mode == MCA, (m_mode == MET) || (m_mode == MEA),
            m_mode == MEA, c};
  endfunction

  // Apply the increment rules on the time as hour/minute numbers.
  task automatic model_inc();
    int t, u, lim;
    case (m_cur)
      0: begin
        t = (m_hh / 10 + 1) % 3;
        u = m_hh % 10;
        if (t == 2 && u > 3) u = 3;
        m_hh = t * 10 + u;
      end
      1: begin
        lim = (m_hh / 10 == 2) ? 4 : 10;
        m_hh = (m_hh / 10) * 10 + (m_hh % 10 + 1) % lim;
      end
      2: m_mm = ((m_mm / 10 + 1) % 6) * 10 + m_mm % 10;
      default: m_mm = (m_mm / 10) * 10 + (m_mm % 10 + 1) % 10;
    endcase
  endtask

  // What the session looks like after the next rising edge, given these button levels.
  task automatic model_step(input bit [3:0] lv, input int chh, input int cmm);
    bit [3:0] e;
    e = lv & ~m_prev;
    m_prev = lv;
    case (m_mode)
      MI: if (e[0]) begin
        m_mode = MET; m_hh = chh; m_mm = cmm; m_cur = 0; m_idle = 0;
      end
      MET, MEA: begin
        if (e != 0) m_idle = 0;
        else if (m_idle == TO - 1) m_mode = MI;
        else m_idle++;
        if (e[0]) begin
          if (m_mode == MET) begin
            m_mode = MEA; m_hh = m_sh_hh; m_mm = m_sh_mm; m_cur = 0;
          end else m_mode = MI;
        end else if (e[1]) begin
          if (m_mode == MET) m_mode = MCT;
          else begin
            m_mode = MCA; m_sh_hh = m_hh; m_sh_mm = m_mm;
          end
        end else if (e[2]) m_cur = (m_cur + 1) % 4;
        else if (e[3]) model_inc();
      end
      default: m_mode = MI;
    endcase
  endtask

  initial begin
    bit [3:0] lv;
    int       rhh, rmm;
    logic     ld_seen;

    // reset with mode held; current time 13:47
    reset = 1'b1;
    drive(4'b0001);
    set_cur(13, 47);
    @(negedge clk_1s);
    @(negedge clk_1s);
    check("rst_digits", obs_dig(), 16'h0);
    check("rst_flags", obs_flags(), 16'h0);
    reset = 1'b0;
    @(negedge clk_1s);
    @(negedge clk_1s);
    check("held_through_reset", 16'(editing), 16'h0);
    drive(4'b0);
    @(negedge clk_1s);

    // enter time edit, seeded from 13:47
    press(4'b0001);
    check("enter_time_digits", obs_dig(), mk_dig(13, 47));
    check("enter_time_flags", obs_flags(), 16'b0010_00);

    // H1 -> 2 (H0 stays within 0..3), cursor H0, H0 3 wraps to 0
    press(4'b1000);
    check("inc_h1", obs_dig(), mk_dig(23, 47));
    press(4'b0100);
    check("sel_h0", 16'(cursor), 16'd1);
    press(4'b1000);
    check("inc_h0_wrap", obs_dig(), mk_dig(20, 47));
    drive(4'b0010);
    @(negedge clk_1s);
    check("ld_time_on", {14'b0, LD_time, LD_alarm}, 16'b10);
    check("ld_time_digits", obs_dig(), mk_dig(20, 47));
    drive(4'b0);
    @(negedge clk_1s);
    check("ld_time_off", {13'b0, LD_time, LD_alarm, editing}, 16'b0);

    // alarm edit from shadow 00:00, M0 wraps after ten incs then set to 03
    press(4'b0001);
    press(4'b0001);
    check("alarm_shadow_init", obs_dig(), mk_dig(0, 0));
    check("alarm_flags", obs_flags(), 16'b0011_00);
    repeat (3) press(4'b0100);
    check("sel_m0", 16'(cursor), 16'd3);
    repeat (10) press(4'b1000);
    check("m0_wrap", obs_dig(), mk_dig(0, 0));
    repeat (3) press(4'b1000);
    check("m0_three", obs_dig(), mk_dig(0, 3));
    drive(4'b0010);
    @(negedge clk_1s);
    check("ld_alarm_on", {14'b0, LD_time, LD_alarm}, 16'b01);
    drive(4'b0);
    @(negedge clk_1s);
    check("ld_alarm_off", {13'b0, LD_time, LD_alarm, editing}, 16'b0);
    press(4'b0001);
    press(4'b0001);
    check("alarm_shadow_kept", obs_dig(), mk_dig(0, 3));
    press(4'b0001);
    check("alarm_abort_idle", 16'(editing), 16'h0);

    // timeout: 30 quiet cycles in edit, then idle without strobes
    drive(4'b0001);
    @(negedge clk_1s);
    drive(4'b0);
    ld_seen = LD_time | LD_alarm;
    check("tmo_enter", 16'(editing), 16'h1);
    for (int i = 2; i <= TO; i++) begin
      @(negedge clk_1s);
      ld_seen = ld_seen | LD_time | LD_alarm;
    end
    check("tmo_last_cycle", 16'(editing), 16'h1);
    @(negedge clk_1s);
    ld_seen = ld_seen | LD_time | LD_alarm;
    check("tmo_exit", 16'(editing), 16'h0);
    check("tmo_no_strobe", 16'(ld_seen), 16'h0);

    // simultaneous mode+load+inc: only mode acts
    press(4'b0001);
    press(4'b0100);
    drive(4'b1011);
    @(negedge clk_1s);
    check("prio_flags", obs_flags(), 16'b0011_00);
    check("prio_digits", obs_dig(), mk_dig(0, 3));
    drive(4'b0);
    @(negedge clk_1s);
    check("prio_no_strobe", {14'b0, LD_time, LD_alarm}, 16'b0);
    press(4'b0001);

    // reset in the commit cycle cuts the strobe immediately
    press(4'b0001);
    drive(4'b0010);
    @(negedge clk_1s);
    check("commit_before_reset", 16'(LD_time), 16'h1);
    #2 reset = 1'b1;
    #1;
    check("reset_cuts_strobe", obs_flags(), 16'h0);
    check("reset_clears_digits", obs_dig(), 16'h0);
    drive(4'b0);
    @(negedge clk_1s);
    reset = 1'b0;
    @(negedge clk_1s);
    @(negedge clk_1s);

    // random traffic against the session model
    m_mode = MI; m_hh = 0; m_mm = 0; m_sh_hh = 0; m_sh_mm = 0;
    m_cur = 0; m_idle = 0; m_prev = 4'b0;
    repeat (600) begin
      check("rnd_digits", obs_dig(), mk_dig(m_hh, m_mm));
      check("rnd_flags", obs_flags(), exp_flags());
      lv[0] = ($urandom_range(0, 9) == 0);
      lv[1] = ($urandom_range(0, 9) == 0);
      lv[2] = ($urandom_range(0, 3) == 0);
      lv[3] = ($urandom_range(0, 1) == 0);
      rhh = int'($urandom_range(0, 23));
      rmm = int'($urandom_range(0, 59));
      set_cur(rhh, rmm);
      drive(lv);
      model_step(lv, rhh, rmm);
      @(negedge clk_1s);
    end
    check("rnd_final_digits", obs_dig(), mk_dig(m_hh, m_mm));
    check("rnd_final_flags", obs_flags(), exp_flags());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
